// File: rtl/rr_arbiter8_pkg.sv
// Shared widths and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int unsigned NREQ   = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter8_onehot_dec3.sv
// 3-to-8 one-hot decoder with enable.
//   idx      : binary index
//   en       : when low, output is all zeros
//   onehot_c : one-hot decode of idx (combinational)
module onehot_dec3
  import rr_arbiter8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold limit.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : request vector, bit i = requester i
//   done      : owner releases the grant (ignored when idle)
//   gnt       : one-hot grant decoded from registered gnt_idx/gnt_valid
//   gnt_idx   : binary owner index, holds last value when idle
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse after a hold-limit forced release
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // Hold count value at which the grant is forced off; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? HOLD_W'(0) : HOLD_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic               gnt_valid_d;
  logic               timeout_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   scan_idx;

  logic               rel_done;
  logic               rel_drop;
  logic               rel_expire;
  logic               release_c;

  // Rotating priority search: first set request starting at ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IDX_W'(ptr_q + IDX_W'(i));
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    rel_done   = done;
    rel_drop   = !req[gnt_idx];
    rel_expire = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    release_c  = rel_done || rel_drop || rel_expire;
  end

  // State register and registered datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_GRANT;
      ST_GRANT: if (release_c)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          ptr_d     = IDX_W'(gnt_idx + IDX_W'(1));
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = rel_expire && !rel_done && !rel_drop;
        end else begin
          gnt_valid_d = 1'b1;
          if (hold_q != '1) hold_d = HOLD_W'(hold_q + HOLD_W'(1));
        end
      end
      default: ;
    endcase
  end

  onehot_dec3 u_gnt_dec (
    .idx      (gnt_idx),
    .en       (gnt_valid),
    .onehot_c (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (MAX_HOLD = 16, 4 and 0).
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b, req_c;
  logic       done_a, done_b, done_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       tmo_a, tmo_b, tmo_c;

  int n_checks;
  int n_pass;
  int hi_cnt;
  int to_cnt;

  rr_arbiter8 #(.MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(tmo_a)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(tmo_b)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .done(done_c),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .timeout(tmo_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_a(input string tag, input logic [7:0] g, input logic [2:0] i,
                          input logic v, input logic t);
    check({tag, ".gnt"},       32'(gnt_a), 32'(g));
    check({tag, ".gnt_idx"},   32'(idx_a), 32'(i));
    check({tag, ".gnt_valid"}, 32'(val_a), 32'(v));
    check({tag, ".timeout"},   32'(tmo_a), 32'(t));
  endtask

  task automatic expect_b(input string tag, input logic [7:0] g, input logic [2:0] i,
                          input logic v, input logic t);
    check({tag, ".gnt"},       32'(gnt_b), 32'(g));
    check({tag, ".gnt_idx"},   32'(idx_b), 32'(i));
    check({tag, ".gnt_valid"}, 32'(val_b), 32'(v));
    check({tag, ".timeout"},   32'(tmo_b), 32'(t));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req_a    = 8'hFF; done_a = 1'b0;
    req_b    = 8'h00; done_b = 1'b0;
    req_c    = 8'h00; done_c = 1'b0;

    // Reset held two cycles with all requests asserted
    tick();
    tick();
    expect_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    check("reset_b.gnt", 32'(gnt_b), 32'h0);
    check("reset_c.gnt", 32'(gnt_c), 32'h0);
    rst_n = 1'b1;
    tick();
    expect_a("first", 8'h01, 3'd0, 1'b1, 1'b0);

    // Full rotation with done asserted throughout
    done_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_a("rot_gap", 8'h00, 3'(k), 1'b0, 1'b0);
      tick();
      expect_a("rot_gnt", 8'(1 << ((k + 1) % 8)), 3'((k + 1) % 8), 1'b1, 1'b0);
    end

    // Sparse fairness: requesters 0 and 2
    req_a = 8'b0000_0101;
    do_reset();
    tick(); expect_a("sparse0", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); expect_a("sparse1", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); expect_a("sparse2", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); expect_a("sparse3", 8'h00, 3'd2, 1'b0, 1'b0);
    tick(); expect_a("sparse4", 8'h01, 3'd0, 1'b1, 1'b0);
    tick(); expect_a("sparse5", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); expect_a("sparse6", 8'h04, 3'd2, 1'b1, 1'b0);

    // Owner 5, no preemption by requester 0, then request drop
    done_a = 1'b0;
    req_a  = 8'h20;
    do_reset();
    tick(); expect_a("drop_gnt", 8'h20, 3'd5, 1'b1, 1'b0);
    req_a = 8'h21;
    tick(); expect_a("no_preempt", 8'h20, 3'd5, 1'b1, 1'b0);
    req_a = 8'h00;
    tick(); expect_a("drop_rel", 8'h00, 3'd5, 1'b0, 1'b0);

    // Reset in the middle of a grant clears the pointer
    req_a = 8'h40;
    do_reset();
    tick(); expect_a("mid_gnt", 8'h40, 3'd6, 1'b1, 1'b0);
    req_a = 8'hFF;
    rst_n = 1'b0;
    tick(); expect_a("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); expect_a("mid_regrant", 8'h01, 3'd0, 1'b1, 1'b0);

    // Default hold limit of 16 on requester 1
    req_a = 8'h02;
    do_reset();
    hi_cnt = 0;
    repeat (16) begin
      tick();
      if (gnt_a == 8'h02 && !tmo_a) hi_cnt++;
    end
    check("hold16.cycles", 32'(hi_cnt), 32'd16);
    tick(); expect_a("hold16.rel", 8'h00, 3'd1, 1'b0, 1'b1);
    req_a = 8'h00;

    // Hold limit 4: four grant cycles, timeout pulse, then re-grant
    req_b = 8'h08;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_b("to_hold", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick(); expect_b("to_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    tick(); expect_b("to_regrant", 8'h08, 3'd3, 1'b1, 1'b0);

    // done coincident with hold-limit expiry: no timeout
    do_reset();
    repeat (4) tick();
    check("tie.pre", 32'(gnt_b), 32'h08);
    done_b = 1'b1;
    tick(); expect_b("tie_rel", 8'h00, 3'd3, 1'b0, 1'b0);
    done_b = 1'b0;
    req_b  = 8'h00;

    // No hold limit: grant persists for 300 cycles
    req_c = 8'h01;
    do_reset();
    hi_cnt = 0;
    to_cnt = 0;
    repeat (300) begin
      tick();
      if (gnt_c == 8'h01) hi_cnt++;
      if (tmo_c) to_cnt++;
    end
    check("nolimit.cycles", 32'(hi_cnt), 32'd300);
    check("nolimit.timeouts", 32'(to_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
